// File: rtl/ibex_wb_arbiter.sv
// Writeback arbiter: merges EX results and buffered FPU results onto the single
// register-file write port, and tracks in-flight FP destinations for ID hazards.
module ibex_wb_arbiter #(
  parameter int unsigned FpFifoDepth  = 2,
  parameter bit          WritebackReg = 1'b1,
  localparam int unsigned CW          = $clog2(FpFifoDepth) + 1,
  localparam int unsigned PW          = $clog2(FpFifoDepth)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          ex_valid_i,
  input  logic          ex_we_i,
  input  logic [4:0]    ex_rd_i,
  input  logic [31:0]   ex_result_i,
  output logic          ex_ready_o,
  input  logic          fp_issue_valid_i,
  input  logic [4:0]    fp_issue_rd_i,
  output logic          fp_issue_ready_o,
  input  logic          fp_out_valid_i,
  input  logic [31:0]   fp_result_i,
  input  logic [4:0]    fp_rd_i,
  output logic          fp_out_ready_o,
  input  logic [4:0]    rs1_i,
  input  logic [4:0]    rs2_i,
  input  logic [4:0]    rs3_i,
  output logic          hazard_o,
  output logic          rf_we_o,
  output logic [4:0]    rf_waddr_o,
  output logic [31:0]   rf_wdata_o,
  output logic [CW-1:0] fifo_count_o
);

  logic [31:0]   fifo_data_q [FpFifoDepth];
  logic [4:0]    fifo_rd_q   [FpFifoDepth];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [31:0]   pending_q, pending_d;

  logic          fifo_full, fifo_empty;
  logic          fifo_push, fifo_pop;
  logic          ex_wins, issue_fire;
  logic [4:0]    head_rd;
  logic [31:0]   head_data;

  logic          wb_we;
  logic [4:0]    wb_addr;
  logic [31:0]   wb_data;

  logic [5:0]    pend_cnt;
  logic [CW-1:0] outstanding;

  assign fifo_full  = (count_q == CW'(FpFifoDepth));
  assign fifo_empty = (count_q == '0);
  assign head_rd    = fifo_rd_q[rd_ptr_q];
  assign head_data  = fifo_data_q[rd_ptr_q];

  // A full FIFO always takes the port so it can never deadlock against EX.
  assign ex_ready_o     = !fifo_full;
  assign ex_wins        = ex_valid_i & ex_we_i & (ex_rd_i != 5'd0) & !fifo_full;
  assign fifo_pop       = !fifo_empty & !ex_wins;
  assign fp_out_ready_o = !fifo_full | fifo_pop;
  assign fifo_push      = fp_out_valid_i & fp_out_ready_o & (fp_rd_i != 5'd0);

  assign wb_we   = ex_wins | fifo_pop;
  assign wb_addr = ex_wins ? ex_rd_i : head_rd;
  assign wb_data = ex_wins ? ex_result_i : head_data;

  always_ff @(posedge clk_i) begin
    if (fifo_push) begin
      fifo_data_q[wr_ptr_q] <= fp_result_i;
      fifo_rd_q[wr_ptr_q]   <= fp_rd_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (fifo_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (fifo_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({fifo_push, fifo_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign fifo_count_o = count_q;

  always_comb begin
    pend_cnt = '0;
    for (int i = 1; i < 32; i++) pend_cnt = pend_cnt + 6'(pending_q[i]);
  end

  // Entries already in the FIFO are still counted as pending, so this is
  // conservative: every accepted issue is guaranteed a FIFO slot.
  assign outstanding = (pend_cnt >= 6'(FpFifoDepth)) ? CW'(FpFifoDepth) : CW'(pend_cnt);

  assign fp_issue_ready_o = !pending_q[fp_issue_rd_i] &
                            (({1'b0, count_q} + {1'b0, outstanding}) < (CW+1)'(FpFifoDepth));
  assign issue_fire       = fp_issue_valid_i & fp_issue_ready_o & (fp_issue_rd_i != 5'd0);

  always_comb begin
    pending_d = pending_q;
    if (fifo_pop)   pending_d[head_rd]       = 1'b0;
    if (issue_fire) pending_d[fp_issue_rd_i] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) pending_q <= '0;
    else       pending_q <= pending_d;
  end

  assign hazard_o = pending_q[rs1_i] | pending_q[rs2_i] | pending_q[rs3_i];

  if (WritebackReg) begin : g_wb_reg
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        rf_we_o    <= 1'b0;
        rf_waddr_o <= '0;
        rf_wdata_o <= '0;
      end else begin
        rf_we_o    <= wb_we;
        rf_waddr_o <= wb_addr;
        rf_wdata_o <= wb_data;
      end
    end
  end else begin : g_wb_comb
    assign rf_we_o    = wb_we;
    assign rf_waddr_o = wb_addr;
    assign rf_wdata_o = wb_data;
  end

endmodule

// File: tb/tb_ibex_wb_arbiter.sv
// Scenario bench for ibex_wb_arbiter (depth 2, registered writeback); register
// writes are checked in order against a queue of expected {addr,data}.
module tb_ibex_wb_arbiter;
  localparam int Depth = 2;
  localparam int CW    = $clog2(Depth) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ex_valid, ex_we;
  logic [4:0]    ex_rd;
  logic [31:0]   ex_result;
  logic          ex_ready;
  logic          iss_valid;
  logic [4:0]    iss_rd;
  logic          iss_ready;
  logic          fpo_valid;
  logic [31:0]   fp_result;
  logic [4:0]    fp_rd;
  logic          fpo_ready;
  logic [4:0]    rs1, rs2, rs3;
  logic          hazard;
  logic          rf_we;
  logic [4:0]    rf_waddr;
  logic [31:0]   rf_wdata;
  logic [CW-1:0] fifo_count;

  int checks = 0;
  int errors = 0;
  logic [36:0] exp_q[$];
  logic [36:0] mon_exp;

  always #5 clk = ~clk;

  ibex_wb_arbiter #(.FpFifoDepth(Depth), .WritebackReg(1'b1)) dut (
    .clk_i(clk), .rst_i(rst),
    .ex_valid_i(ex_valid), .ex_we_i(ex_we), .ex_rd_i(ex_rd), .ex_result_i(ex_result),
    .ex_ready_o(ex_ready),
    .fp_issue_valid_i(iss_valid), .fp_issue_rd_i(iss_rd), .fp_issue_ready_o(iss_ready),
    .fp_out_valid_i(fpo_valid), .fp_result_i(fp_result), .fp_rd_i(fp_rd),
    .fp_out_ready_o(fpo_ready),
    .rs1_i(rs1), .rs2_i(rs2), .rs3_i(rs3), .hazard_o(hazard),
    .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
    .fifo_count_o(fifo_count)
  );

  // Every register-file write must match the oldest expected write.
  always @(negedge clk) begin
    if (rf_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rf_write unexpected: got x%0d=%h, expected no write", rf_waddr, rf_wdata);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({rf_waddr, rf_wdata} !== mon_exp) begin
          errors++;
          $display("FAIL rf_write: got x%0d=%h, expected x%0d=%h",
                   rf_waddr, rf_wdata, mon_exp[36:32], mon_exp[31:0]);
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ex_valid = 0; ex_we = 0; ex_rd = 0; ex_result = 0;
    iss_valid = 0; iss_rd = 0;
    fpo_valid = 0; fp_result = 0; fp_rd = 0;
    rs1 = 0; rs2 = 0; rs3 = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    checks++; if ({rf_we, rf_waddr, rf_wdata} !== 38'd0) begin errors++;
      $display("FAIL reset_rf: got %h, expected 0", {rf_we, rf_waddr, rf_wdata}); end
    checks++; if (fifo_count !== 2'd0) begin errors++;
      $display("FAIL reset_count: got %0d, expected 0", fifo_count); end
    checks++; if ({ex_ready, fpo_ready, iss_ready, hazard} !== 4'b1110) begin errors++;
      $display("FAIL reset_flags: got %b, expected 1110", {ex_ready, fpo_ready, iss_ready, hazard}); end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    ex_valid = 1; ex_we = 1; ex_rd = 5; ex_result = 32'h11;
    exp_q.push_back({5'd5, 32'h11});
    @(negedge clk);
    checks++; if (ex_ready !== 1'b1) begin errors++;
      $display("FAIL b2b_ready0: got %b, expected 1", ex_ready); end
    next_cycle();
    ex_rd = 6; ex_result = 32'h22;
    exp_q.push_back({5'd6, 32'h22});
    @(negedge clk);
    checks++; if (ex_ready !== 1'b1) begin errors++;
      $display("FAIL b2b_ready1: got %b, expected 1", ex_ready); end
    checks++; if ({rf_we, rf_waddr} !== {1'b1, 5'd5}) begin errors++;
      $display("FAIL b2b_x5_timing: got we=%b addr=%0d, expected we=1 addr=5", rf_we, rf_waddr); end
    next_cycle();
    clear_inputs();
    @(negedge clk);
    checks++; if ({rf_we, rf_waddr} !== {1'b1, 5'd6}) begin errors++;
      $display("FAIL b2b_x6_timing: got we=%b addr=%0d, expected we=1 addr=6", rf_we, rf_waddr); end
    next_cycle();
  endtask

  task automatic test_collision();
    iss_valid = 1; iss_rd = 4;
    next_cycle();
    clear_inputs();
    ex_valid = 1; ex_we = 1; ex_rd = 9; ex_result = 32'hAAAA;
    fpo_valid = 1; fp_rd = 4; fp_result = 32'h3F80_0000; rs1 = 4;
    exp_q.push_back({5'd9, 32'hAAAA});
    exp_q.push_back({5'd4, 32'h3F80_0000});
    @(negedge clk);
    checks++; if (hazard !== 1'b1) begin errors++;
      $display("FAIL coll_hazard_set: got %b, expected 1", hazard); end
    next_cycle();
    clear_inputs(); rs1 = 4;
    @(negedge clk);
    checks++; if ({hazard, fifo_count} !== {1'b1, 2'd1}) begin errors++;
      $display("FAIL coll_queued: got hazard=%b count=%0d, expected 1/1", hazard, fifo_count); end
    next_cycle();
    @(negedge clk);
    checks++; if ({hazard, rf_we, rf_waddr, fifo_count} !== {1'b0, 1'b1, 5'd4, 2'd0}) begin errors++;
      $display("FAIL coll_x4_write: got hazard=%b we=%b addr=%0d count=%0d, expected 0/1/4/0",
               hazard, rf_we, rf_waddr, fifo_count); end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_fifo_full();
    ex_valid = 1; ex_we = 1; ex_rd = 10; ex_result = 32'hA0;
    fpo_valid = 1; fp_rd = 11; fp_result = 32'hB0;
    exp_q.push_back({5'd10, 32'hA0});
    next_cycle();
    ex_rd = 12; ex_result = 32'hA1; fp_rd = 13; fp_result = 32'hB1;
    exp_q.push_back({5'd12, 32'hA1});
    next_cycle();
    fpo_valid = 0; ex_rd = 14; ex_result = 32'hA2;
    exp_q.push_back({5'd11, 32'hB0});
    @(negedge clk);
    checks++; if ({ex_ready, fpo_ready, fifo_count} !== {1'b0, 1'b1, 2'd2}) begin errors++;
      $display("FAIL full_popthrough: got ex_ready=%b fp_ready=%b count=%0d, expected 0/1/2",
               ex_ready, fpo_ready, fifo_count); end
    next_cycle();
    exp_q.push_back({5'd14, 32'hA2});
    @(negedge clk);
    checks++; if ({ex_ready, fifo_count} !== {1'b1, 2'd1}) begin errors++;
      $display("FAIL full_drained: got ex_ready=%b count=%0d, expected 1/1", ex_ready, fifo_count); end
    next_cycle();
    clear_inputs();
    exp_q.push_back({5'd13, 32'hB1});
    next_cycle();
    @(negedge clk);
    checks++; if (fifo_count !== 2'd0) begin errors++;
      $display("FAIL full_empty: got count=%0d, expected 0", fifo_count); end
    next_cycle();
  endtask

  task automatic test_waw();
    iss_valid = 1; iss_rd = 8; rs2 = 8;
    @(negedge clk);
    checks++; if (iss_ready !== 1'b1) begin errors++;
      $display("FAIL waw_first_issue: got %b, expected 1", iss_ready); end
    next_cycle();
    @(negedge clk);
    checks++; if ({iss_ready, hazard} !== 2'b01) begin errors++;
      $display("FAIL waw_blocked: got ready=%b hazard=%b, expected 0/1", iss_ready, hazard); end
    next_cycle();
    fpo_valid = 1; fp_rd = 8; fp_result = 32'h1234;
    exp_q.push_back({5'd8, 32'h1234});
    next_cycle();
    fpo_valid = 0;
    @(negedge clk);
    checks++; if ({iss_ready, hazard} !== 2'b01) begin errors++;
      $display("FAIL waw_blocked_queued: got ready=%b hazard=%b, expected 0/1", iss_ready, hazard); end
    next_cycle();
    @(negedge clk);
    checks++; if ({iss_ready, rf_we, rf_waddr} !== {1'b1, 1'b1, 5'd8}) begin errors++;
      $display("FAIL waw_released: got ready=%b we=%b addr=%0d, expected 1/1/8", iss_ready, rf_we, rf_waddr); end
    next_cycle();
    iss_valid = 0;
    fpo_valid = 1; fp_rd = 8; fp_result = 32'h5678;
    exp_q.push_back({5'd8, 32'h5678});
    @(negedge clk);
    checks++; if (hazard !== 1'b1) begin errors++;
      $display("FAIL waw_second_pending: got %b, expected 1", hazard); end
    next_cycle();
    fpo_valid = 0;
    next_cycle();
    @(negedge clk);
    checks++; if (hazard !== 1'b0) begin errors++;
      $display("FAIL waw_cleared: got %b, expected 0", hazard); end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_x0();
    ex_valid = 1; ex_we = 1; ex_rd = 0; ex_result = 32'hDEAD;
    fpo_valid = 1; fp_rd = 0; fp_result = 32'hBEEF;
    iss_valid = 1; iss_rd = 0;
    @(negedge clk);
    checks++; if ({ex_ready, fpo_ready} !== 2'b11) begin errors++;
      $display("FAIL x0_ready: got %b, expected 11", {ex_ready, fpo_ready}); end
    next_cycle();
    ex_we = 0; ex_rd = 3; fpo_valid = 0; iss_valid = 0;
    @(negedge clk);
    checks++; if ({rf_we, fifo_count, hazard} !== {1'b0, 2'd0, 1'b0}) begin errors++;
      $display("FAIL x0_no_effect: got we=%b count=%0d hazard=%b, expected 0/0/0", rf_we, fifo_count, hazard); end
    checks++; if (ex_ready !== 1'b1) begin errors++;
      $display("FAIL nowe_ready: got %b, expected 1", ex_ready); end
    next_cycle();
    clear_inputs();
    @(negedge clk);
    checks++; if (rf_we !== 1'b0) begin errors++;
      $display("FAIL nowe_no_write: got %b, expected 0", rf_we); end
    next_cycle();
  endtask

  task automatic test_reset_mid_op();
    iss_valid = 1; iss_rd = 3;
    next_cycle();
    iss_rd = 7;
    @(negedge clk);
    checks++; if (iss_ready !== 1'b1) begin errors++;
      $display("FAIL rst_mid_issue7: got %b, expected 1", iss_ready); end
    next_cycle();
    iss_valid = 0;
    ex_valid = 1; ex_we = 1; ex_rd = 1; ex_result = 32'h101;
    fpo_valid = 1; fp_rd = 20; fp_result = 32'h2020;
    exp_q.push_back({5'd1, 32'h101});
    next_cycle();
    ex_rd = 2; ex_result = 32'h202; fp_rd = 21; fp_result = 32'h2121;
    exp_q.push_back({5'd2, 32'h202});
    next_cycle();
    clear_inputs(); rs1 = 3; rs3 = 7;
    rst = 1;
    @(negedge clk);
    checks++; if ({fifo_count, hazard} !== {2'd2, 1'b1}) begin errors++;
      $display("FAIL rst_mid_before: got count=%0d hazard=%b, expected 2/1", fifo_count, hazard); end
    next_cycle();
    rst = 0; rs3 = 0;
    @(negedge clk);
    checks++; if ({rf_we, fifo_count, hazard} !== {1'b0, 2'd0, 1'b0}) begin errors++;
      $display("FAIL rst_mid_after: got we=%b count=%0d hazard=%b, expected 0/0/0", rf_we, fifo_count, hazard); end
    rs1 = 7;
    #1;
    checks++; if (hazard !== 1'b0) begin errors++;
      $display("FAIL rst_mid_pending7: got %b, expected 0", hazard); end
    next_cycle();
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_back_to_back();
    test_collision();
    test_fifo_full();
    test_waw();
    test_x0();
    test_reset_mid_op();
    repeat (3) next_cycle();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_writes: got %0d outstanding, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ibex_wb_arbiter.md
Name: ibex_wb_arbiter

Overview:
- Writeback stage directly downstream of the execute block.
- Merges two result streams into the single register-file write port: single-cycle/multi-cycle integer results (ALU, MUL/DIV) and out-of-band FP results from the FPnew unit (valid/ready).
- Buffers FP results in a small FIFO.
- Keeps a pending-destination scoreboard so ID stalls on RAW/WAW hazards against in-flight FP operations.

Parameters:
- FpFifoDepth, 2, FP result FIFO entries; power of two, 2..8.
- WritebackReg, 1, 1 = register-file write outputs registered (1-cycle latency); 0 = combinational.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- ex_valid_i  in  1  EX result valid (EX valid output qualified by instruction in EX)
- ex_we_i  in  1  integer instruction writes rd
- ex_rd_i  in  5  integer destination
- ex_result_i  in  32  EX result
- ex_ready_o  out  1  writeback accepts EX result this cycle
- fp_issue_valid_i  in  1  FP op issued to FPU this cycle
- fp_issue_rd_i  in  5  FP op destination
- fp_issue_ready_o  out  1  issue permitted (no WAW on pending rd, FIFO not full)
- fp_out_valid_i  in  1  FPU result valid
- fp_result_i  in  32  FPU result
- fp_rd_i  in  5  FPU result destination (tag)
- fp_out_ready_o  out  1  FIFO can accept FPU result
- rs1_i, rs2_i, rs3_i  in  5 each  ID source addresses
- hazard_o  out  1  any rsN of ID matches a pending FP destination
- rf_we_o  out  1  register-file write enable
- rf_waddr_o  out  5  write address
- rf_wdata_o  out  32  write data
- fifo_count_o  out  $clog2(FpFifoDepth)+1  FIFO occupancy (debug/perf)

Behaviour:
- Reset (rst_i high at clk_i edge):
  - FIFO pointers and count = 0; pending mask = 0.
  - rf_we_o = 0, rf_waddr_o = 0, rf_wdata_o = 0.
  - Takes priority over every other event in the same cycle.
- FIFO:
  - Push when fp_out_valid_i & fp_out_ready_o.
  - fp_out_ready_o = (count < FpFifoDepth), or count == FpFifoDepth with a pop this cycle (pop-through).
  - Pointers wrap modulo FpFifoDepth.
  - Simultaneous push and pop leaves count unchanged.
  - Push with rd = 0 is accepted and discarded (never enters the FIFO).
- Arbitration, one write per cycle:
  - FIFO full: FIFO head wins; ex_ready_o = 0.
  - Otherwise: EX wins when ex_valid_i & ex_we_i; else FIFO head if not empty.
  - ex_ready_o = 1 whenever EX is not blocked (including ex_we_i = 0).
  - EX result with rd = 0 completes without writing; the FIFO may use the port that cycle.
- Write port:
  - WritebackReg = 1: the winner appears on rf_* the next cycle.
  - WritebackReg = 0: same cycle.
  - rf_we_o never asserted with rf_waddr_o = 0.
- Scoreboard, 32-bit pending mask:
  - Set bit fp_issue_rd_i on fp_issue_valid_i & fp_issue_ready_o, if rd != 0.
  - Clear bit when the FIFO head for that rd is popped to the write port.
  - Set and clear of the same bit in the same cycle: set wins.
- fp_issue_ready_o = !pending[fp_issue_rd_i] & (count + outstanding < FpFifoDepth).
  - outstanding = popcount of pending mask, capped; guarantees FIFO space for every issued op.
- hazard_o:
  - Combinational OR of pending[rs1_i], pending[rs2_i], pending[rs3_i].
  - Bit 0 is never pending.
- Data-hazard bypass is not provided; ID stalls on hazard_o.

Test Plan:
- Reset mid-operation: FIFO holding 2 entries, pending bits 3 and 7, rst_i = 1 for 1 cycle → count 0, pending 0, rf_we_o = 0 next cycle, hazard_o = 0 for rs1 = 3.
- Back-to-back EX writes: x5 = 0x11, x6 = 0x22 on consecutive cycles → rf writes on cycles +1 and +2 with matching addr/data; ex_ready_o held 1.
- Collision: EX writes x9 = 0xAAAA while an FP result for x4 = 0x3F800000 arrives → x9 written first, x4 one cycle later; pending[4] clears on the x4 write.
- FIFO full, depth 2: two FP results queued while EX is busy every cycle → ex_ready_o = 0 for one cycle and the FIFO head drains; fp_out_ready_o stays 1 through the pop-through cycle.
- WAW: issue to x8, then issue to x8 again → fp_issue_ready_o = 0 until the first x8 result is written; rs2_i = 8 gives hazard_o = 1 until then.
- x0 handling: FP result and EX result both targeting x0 → no rf_we_o pulse, no pending bit set, FIFO count unchanged.
